// File: rtl/ht_cmd_if.sv
// Hash table command handshake: the master drives cmd/valid, the slave drives ready.
interface ht_cmd_if #(
    parameter int unsigned CMD_W = 32
);
    logic [CMD_W-1:0] cmd;
    logic             valid;
    logic             ready;

    modport master (output cmd, output valid, input ready);
    modport slave  (input cmd, input valid, output ready);
endinterface

// File: rtl/ht_cmd_arb.sv
// Two-source round-robin command arbiter with bounded bursts and a 2-entry output buffer.
// Per-source statistics counters are built only when HT_CMD_ARB_STATS_EN is defined.
module ht_cmd_arb #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned CMD_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    ht_cmd_if.slave          ht_cmd_a_in,
    ht_cmd_if.slave          ht_cmd_b_in,
    ht_cmd_if.master         ht_cmd_out,
    input  logic             stats_clr_i,
    output logic [CNT_W-1:0] cnt_a_o,
    output logic [CNT_W-1:0] cnt_b_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    src_e             last_src;
    logic [7:0]       burst_cnt;
    logic             run;

    logic [CMD_W-1:0] fifo_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       occ;

    logic             accept_en;
    logic             gnt_valid;
    src_e             gnt_src;
    logic             push;
    logic             pop;
    logic [CMD_W-1:0] push_cmd;

    // burst_cnt == 0 only before the first accept, so the first contest goes to A.
    always_comb begin
        accept_en = run && (occ != 2'd2);
        gnt_valid = ht_cmd_a_in.valid || ht_cmd_b_in.valid;
        gnt_src   = SRC_A;
        if (ht_cmd_a_in.valid && ht_cmd_b_in.valid) begin
            if ((burst_cnt != 8'd0) && (burst_cnt < MAX_B))
                gnt_src = last_src;
            else
                gnt_src = (last_src == SRC_A) ? SRC_B : SRC_A;
        end else if (ht_cmd_b_in.valid) begin
            gnt_src = SRC_B;
        end
        ht_cmd_a_in.ready = accept_en && gnt_valid && (gnt_src == SRC_A);
        ht_cmd_b_in.ready = accept_en && gnt_valid && (gnt_src == SRC_B);
        push              = accept_en && gnt_valid;
        push_cmd          = (gnt_src == SRC_A) ? ht_cmd_a_in.cmd : ht_cmd_b_in.cmd;
        ht_cmd_out.valid  = (occ != 2'd0);
        ht_cmd_out.cmd    = fifo_mem[rd_ptr];
        pop               = ht_cmd_out.valid && ht_cmd_out.ready;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_src    <= SRC_B;
            burst_cnt   <= 8'd0;
            run         <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= 2'd0;
        end else begin
            run <= 1'b1;
            if (push) begin
                fifo_mem[wr_ptr] <= push_cmd;
                wr_ptr           <= ~wr_ptr;
                if (gnt_src == last_src) begin
                    if (burst_cnt < MAX_B)
                        burst_cnt <= burst_cnt + 8'd1;
                end else begin
                    last_src  <= gnt_src;
                    burst_cnt <= 8'd1;
                end
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: ;
            endcase
        end
    end

`ifdef HT_CMD_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_a     <= '0;
            cnt_b     <= '0;
            stall_cnt <= '0;
        end else if (stats_clr_i) begin
            cnt_a     <= '0;
            cnt_b     <= '0;
            stall_cnt <= '0;
        end else begin
            if (push && (gnt_src == SRC_A))
                cnt_a <= cnt_a + CNT_W'(1);
            if (push && (gnt_src == SRC_B))
                cnt_b <= cnt_b + CNT_W'(1);
            if (ht_cmd_out.valid && !ht_cmd_out.ready)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign cnt_a_o     = cnt_a;
    assign cnt_b_o     = cnt_b;
    assign stall_cnt_o = stall_cnt;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr_i;
    assign cnt_a_o          = '0;
    assign cnt_b_o          = '0;
    assign stall_cnt_o      = '0;
`endif
endmodule

// File: tb/tb_ht_cmd_arb.sv
// Directed bench for ht_cmd_arb; counter expectations follow HT_CMD_ARB_STATS_EN.
module tb_ht_cmd_arb;
    localparam int unsigned CNT_W = 4;
`ifdef HT_CMD_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam logic [31:0] A_BASE = 32'hA000_0000;
    localparam logic [31:0] B_BASE = 32'hB000_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             stats_clr = 1'b0;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic [CNT_W-1:0] stall_cnt;
    int               n_tests = 0;
    int               n_fail = 0;

    ht_cmd_if #(.CMD_W(32)) a_if ();
    ht_cmd_if #(.CMD_W(32)) b_if ();
    ht_cmd_if #(.CMD_W(32)) out_if ();

    ht_cmd_arb #(
        .MAX_BURST(4),
        .CNT_W    (CNT_W),
        .CMD_W    (32)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .ht_cmd_a_in(a_if),
        .ht_cmd_b_in(b_if),
        .ht_cmd_out (out_if),
        .stats_clr_i(stats_clr),
        .cnt_a_o    (cnt_a),
        .cnt_b_o    (cnt_b),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        return STATS ? CNT_W'(n) : '0;
    endfunction

    // Expected merged stream with both sources always valid: A x4, B x4, A x4 ...
    function automatic logic [31:0] rr_exp(input int k);
        logic [31:0] idx;
        idx = 32'((k / 8) * 4 + (k % 4));
        return (((k / 4) % 2) == 0) ? A_BASE + idx : B_BASE + idx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        stats_clr  = 1'b0;
        a_if.valid = 1'b0;
        a_if.cmd   = '0;
        b_if.valid = 1'b0;
        b_if.cmd   = '0;
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_if.valid = 1'b1;
        a_if.cmd   = A_BASE;
        b_if.valid = 1'b1;
        b_if.cmd   = B_BASE;
        out_if.ready = 1'b1;
        repeat (2) tick();
        n_tests++;
        if ({out_if.valid, a_if.ready, b_if.ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid/ra/rb=%b required 000", {out_if.valid, a_if.ready, b_if.ready});
        end
        n_tests++;
        if (out_if.cmd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cmd: got %h required 0", out_if.cmd);
        end
        n_tests++;
        if ({cnt_a, cnt_b, stall_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%h/%h required 0", cnt_a, cnt_b, stall_cnt);
        end
    endtask

    task automatic test_single_source();
        do_reset();
        out_if.ready = 1'b1;
        a_if.valid = 1'b1;
        a_if.cmd   = A_BASE;
        @(negedge clk);
        n_tests++;
        if (a_if.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL first_cycle_ready: got %b required 0", a_if.ready);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if ({a_if.ready, out_if.valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL run_ready: got ready/valid=%b required 10", {a_if.ready, out_if.valid});
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            a_if.cmd   = A_BASE + 32'(k + 1);
            a_if.valid = (k < 2);
            @(negedge clk);
            n_tests++;
            if (out_if.valid !== 1'b1 || out_if.cmd !== A_BASE + 32'(k)) begin
                n_fail++;
                $display("FAIL single_out%0d: got v=%b cmd=%h required v=1 cmd=%h", k, out_if.valid, out_if.cmd, A_BASE + 32'(k));
            end
        end
        n_tests++;
        if (cnt_a !== exp_cnt(3)) begin
            n_fail++;
            $display("FAIL single_cnt_a: got %0d required %0d", cnt_a, exp_cnt(3));
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (out_if.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got valid=%b required 0", out_if.valid);
        end
    endtask

    task automatic test_round_robin();
        int  na, nb, got;
        bit  acc_a, acc_b;
        do_reset();
        out_if.ready = 1'b1;
        a_if.valid = 1'b1;
        a_if.cmd   = A_BASE;
        b_if.valid = 1'b1;
        b_if.cmd   = B_BASE;
        na = 0;
        nb = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 12; c++) begin
            @(negedge clk);
            acc_a = a_if.valid && a_if.ready;
            acc_b = b_if.valid && b_if.ready;
            if (out_if.valid && out_if.ready) begin
                n_tests++;
                if (out_if.cmd !== rr_exp(got)) begin
                    n_fail++;
                    $display("FAIL rr_out%0d: got %h required %h", got, out_if.cmd, rr_exp(got));
                end
                got++;
            end
            tick();
            if (acc_a) begin
                na++;
                a_if.cmd = A_BASE + 32'(na);
            end
            if (acc_b) begin
                nb++;
                b_if.cmd = B_BASE + 32'(nb);
            end
        end
        a_if.valid = 1'b0;
        b_if.valid = 1'b0;
        n_tests++;
        if (got != 12) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d outputs required 12", got);
        end
        @(negedge clk);
        n_tests++;
        if (cnt_a !== exp_cnt(na) || cnt_b !== exp_cnt(nb)) begin
            n_fail++;
            $display("FAIL rr_cnt: got a=%0d b=%0d required a=%0d b=%0d", cnt_a, cnt_b, exp_cnt(na), exp_cnt(nb));
        end
    endtask

    task automatic test_backpressure();
        int na;
        bit acc;
        do_reset();
        out_if.ready = 1'b0;
        a_if.valid = 1'b1;
        a_if.cmd   = A_BASE;
        na = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = a_if.valid && a_if.ready;
            if (c >= 2) begin
                n_tests++;
                if (out_if.valid !== 1'b1 || out_if.cmd !== A_BASE || stall_cnt !== exp_cnt(c - 2)) begin
                    n_fail++;
                    $display("FAIL stall_hold%0d: got v=%b cmd=%h stall=%0d required v=1 cmd=%h stall=%0d",
                             c, out_if.valid, out_if.cmd, stall_cnt, A_BASE, exp_cnt(c - 2));
                end
            end
            tick();
            if (acc) begin
                na++;
                a_if.cmd = A_BASE + 32'(na);
            end
        end
        @(negedge clk);
        n_tests++;
        if (na != 2 || a_if.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_accepts: got %0d accepts ready=%b required 2 accepts ready=0", na, a_if.ready);
        end
        n_tests++;
        if (stall_cnt !== exp_cnt(4) || cnt_a !== exp_cnt(2)) begin
            n_fail++;
            $display("FAIL full_cnt: got stall=%0d a=%0d required stall=%0d a=%0d", stall_cnt, cnt_a, exp_cnt(4), exp_cnt(2));
        end
        a_if.valid = 1'b0;
        out_if.ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_if.valid !== 1'b1 || out_if.cmd !== A_BASE + 32'd1) begin
            n_fail++;
            $display("FAIL drain_second: got v=%b cmd=%h required v=1 cmd=%h", out_if.valid, out_if.cmd, A_BASE + 32'd1);
        end
        @(negedge clk);
        n_tests++;
        if (out_if.valid !== 1'b0 || stall_cnt !== exp_cnt(4)) begin
            n_fail++;
            $display("FAIL drain_done: got v=%b stall=%0d required v=0 stall=%0d", out_if.valid, stall_cnt, exp_cnt(4));
        end
    endtask

    task automatic test_wrap_clear();
        int nb;
        bit acc;
        do_reset();
        out_if.ready = 1'b1;
        b_if.valid = 1'b1;
        b_if.cmd   = B_BASE;
        nb = 0;
        for (int c = 0; c < 40 && nb < 17; c++) begin
            @(negedge clk);
            acc = b_if.valid && b_if.ready;
            tick();
            if (acc) begin
                nb++;
                b_if.cmd = B_BASE + 32'(nb);
            end
        end
        b_if.valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (nb != 17 || cnt_b !== exp_cnt(17) || cnt_a !== exp_cnt(0)) begin
            n_fail++;
            $display("FAIL wrap_cnt: got accepts=%0d b=%0d a=%0d required 17/%0d/%0d", nb, cnt_b, cnt_a, exp_cnt(17), exp_cnt(0));
        end
        b_if.valid = 1'b1;
        stats_clr  = 1'b1;
        #1;
        n_tests++;
        if (b_if.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_accept_ready: got %b required 1", b_if.ready);
        end
        tick();
        stats_clr  = 1'b0;
        b_if.valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cnt_b !== '0 || out_if.valid !== 1'b1 || out_if.cmd !== B_BASE + 32'd17) begin
            n_fail++;
            $display("FAIL clr_priority: got b=%0d v=%b cmd=%h required b=0 v=1 cmd=%h", cnt_b, out_if.valid, out_if.cmd, B_BASE + 32'd17);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_if.ready = 1'b0;
        a_if.valid = 1'b1;
        a_if.cmd   = 32'hDEAD_0001;
        repeat (3) tick();
        @(negedge clk);
        n_tests++;
        if (out_if.valid !== 1'b1 || a_if.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_full: got v=%b ra=%b required v=1 ra=0", out_if.valid, a_if.ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_if.valid, a_if.ready, b_if.ready} !== 3'b000 || out_if.cmd !== 32'h0 || stall_cnt !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v/ra/rb=%b cmd=%h stall=%0d required 000 cmd=0 stall=0",
                     {out_if.valid, a_if.ready, b_if.ready}, out_if.cmd, stall_cnt);
        end
        a_if.valid = 1'b0;
        out_if.ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_if.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL discarded%0d: got valid=%b cmd=%h required valid=0", c, out_if.valid, out_if.cmd);
            end
        end
        tick();
        a_if.valid = 1'b1;
        a_if.cmd   = 32'hC0DE_0042;
        tick();
        a_if.valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (out_if.valid !== 1'b1 || out_if.cmd !== 32'hC0DE_0042) begin
            n_fail++;
            $display("FAIL post_reset_cmd: got v=%b cmd=%h required v=1 cmd=c0de0042", out_if.valid, out_if.cmd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_wrap_clear();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
